// File: rtl/codec_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// codec_cfg_sequencer
//
// Brings up the WM8731 audio codec over the shared I2C byte controller and then
// forwards runtime register writes (volume, mute, ...) to it. After reset it
// waits a power-up delay and writes the seven-entry init table in order. Once
// that is done, it accepts one runtime update at a time from the synth control
// logic. A NACKed transaction is retried after the normal inter-transaction gap.
// If the attempt budget runs out, the sequencer parks in a terminal error state
// until the next reset.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   txn_valid  transaction request to the I2C master (held until accepted)
//   txn_ready  I2C master idle and able to take a transaction
//   txn_addr   7-bit device address (constant DEV_ADDR)
//   txn_data   WM8731 word: [15:9] register, [8:0] data
//   txn_done   one-cycle completion pulse from the I2C master
//   txn_nack   qualifies txn_done: 1 = device NACKed
//   upd_valid  runtime update request
//   upd_ready  update accepted this cycle (only while idle)
//   upd_reg    register of the runtime update
//   upd_data   data of the runtime update
//   init_done  init table written (sticky)
//   busy       high in every state except idle and error
//   error      retries exhausted (sticky until reset)
//   cur_index  index of the current init table entry
// -----------------------------------------------------------------------------
module codec_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'b0011010,
  parameter int         STARTUP_CYCLES = 50000,
  parameter int         GAP_CYCLES     = 500,
  parameter int         MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        txn_valid,
  input  logic        txn_ready,
  output logic [6:0]  txn_addr,
  output logic [15:0] txn_data,
  input  logic        txn_done,
  input  logic        txn_nack,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [6:0]  upd_reg,
  input  logic [8:0]  upd_data,
  output logic        init_done,
  output logic        busy,
  output logic        error,
  output logic [2:0]  cur_index
);

  // Terminal counts of the shared delay counter. The counter runs from 0 up to
  // the terminal value inclusive, so a delay of N yields N+1 cycles in the
  // state. This gives the "reset release -> first request" and
  // "done -> next request" spacing of N+1 cycles.
  localparam logic [19:0] STARTUP_LAST = 20'(STARTUP_CYCLES);
  localparam logic [19:0] GAP_LAST     = 20'(GAP_CYCLES);
  localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRY);
  localparam logic [2:0]  LAST_INDEX   = 3'd6;

  typedef enum logic [2:0] {
    S_BOOT_WAIT,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_IDLE,
    S_ERROR
  } state_t;

  // Init table contents as {register, data}.
  function automatic logic [15:0] rom_word(input logic [2:0] idx);
    logic [6:0] r;
    logic [8:0] d;
    case (idx)
      3'd0:    begin r = 7'h0F; d = 9'h000; end  // reset
      3'd1:    begin r = 7'h06; d = 9'h000; end  // power on
      3'd2:    begin r = 7'h07; d = 9'h00A; end  // I2S, 24-bit
      3'd3:    begin r = 7'h08; d = 9'h000; end  // 48 kHz normal
      3'd4:    begin r = 7'h04; d = 9'h012; end  // DACSEL, mic mute
      3'd5:    begin r = 7'h05; d = 9'h000; end  // DAC unmute
      3'd6:    begin r = 7'h09; d = 9'h001; end  // active
      default: begin r = 7'h00; d = 9'h000; end  // slot 7 is never addressed
    endcase
    return {r, d};
  endfunction

  logic [15:0] init_rom [0:7];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rom
      assign init_rom[gi] = rom_word(3'(gi));
    end
  endgenerate

  state_t      state_reg, state_next;
  logic [19:0] cnt_reg, cnt_next;
  logic [2:0]  index_reg, index_next;
  logic [7:0]  retry_reg, retry_next;
  logic        upd_flag_reg, upd_flag_next;
  logic [15:0] upd_word_reg, upd_word_next;
  logic [15:0] data_reg, data_next;
  logic        init_done_reg, init_done_next;
  logic        error_reg, error_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_BOOT_WAIT;
      cnt_reg       <= '0;
      index_reg     <= '0;
      retry_reg     <= '0;
      upd_flag_reg  <= 1'b0;
      upd_word_reg  <= '0;
      data_reg      <= '0;
      init_done_reg <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      index_reg     <= index_next;
      retry_reg     <= retry_next;
      upd_flag_reg  <= upd_flag_next;
      upd_word_reg  <= upd_word_next;
      data_reg      <= data_next;
      init_done_reg <= init_done_next;
      error_reg     <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    index_next     = index_reg;
    retry_next     = retry_reg;
    upd_flag_next  = upd_flag_reg;
    upd_word_next  = upd_word_reg;
    data_next      = data_reg;
    init_done_next = init_done_reg;
    error_next     = error_reg;

    case (state_reg)
      S_BOOT_WAIT: begin
        if (cnt_reg == STARTUP_LAST) begin
          cnt_next   = '0;
          index_next = '0;
          data_next  = init_rom[0];
          state_next = S_ISSUE;
        end else begin
          cnt_next = cnt_reg + 20'd1;
        end
      end

      // The outgoing word is loaded into data_reg on entry to S_ISSUE. It is
      // not touched again until the next entry, so it stays stable while the
      // request is pending.
      S_ISSUE: begin
        if (txn_ready) begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (txn_done) begin
          if (!txn_nack) begin
            retry_next = '0;
            if (upd_flag_reg) begin
              upd_flag_next = 1'b0;
            end else if (index_reg == LAST_INDEX) begin
              init_done_next = 1'b1;
            end else begin
              index_next = index_reg + 3'd1;
            end
            cnt_next   = '0;
            state_next = S_GAP;
          end else begin
            retry_next = retry_reg + 8'd1;
            if (retry_reg + 8'd1 >= RETRY_LIMIT) begin
              error_next = 1'b1;
              state_next = S_ERROR;
            end else begin
              cnt_next   = '0;
              state_next = S_GAP;
            end
          end
        end
      end

      // A nonzero retry count means the last word was NACKed and must be sent
      // again. index_reg and upd_flag_reg still select that same word.
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          if (!init_done_reg || (retry_reg != 8'd0)) begin
            data_next  = upd_flag_reg ? upd_word_reg : init_rom[index_reg];
            state_next = S_ISSUE;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 20'd1;
        end
      end

      S_IDLE: begin
        if (upd_valid) begin
          upd_word_next = {upd_reg, upd_data};
          upd_flag_next = 1'b1;
          data_next     = {upd_reg, upd_data};
          state_next    = S_ISSUE;
        end
      end

      S_ERROR: begin
        state_next = S_ERROR;
      end

      default: begin
        state_next = S_ERROR;
      end
    endcase
  end

  assign txn_valid = (state_reg == S_ISSUE);
  assign txn_addr  = DEV_ADDR;
  assign txn_data  = data_reg;
  assign upd_ready = (state_reg == S_IDLE);
  assign init_done = init_done_reg;
  assign busy      = (state_reg != S_IDLE) && (state_reg != S_ERROR);
  assign error     = error_reg;
  assign cur_index = index_reg;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_codec_cfg_sequencer
//
// Plays the part of the I2C master and the synth control logic around
// codec_cfg_sequencer. Each session resets the DUT and follows the expected
// transaction stream from a simple model. The model holds the init table as
// register/data pairs, a retry counter and a queue of pending updates. Ready
// stalls, completion latency and NACKs are chosen with $urandom.
// -----------------------------------------------------------------------------
module tb_codec_cfg_sequencer;

  localparam logic [6:0] DEV_ADDR = 7'b0011010;
  localparam int STARTUP = 40;
  localparam int GAP     = 10;
  localparam int RETRY   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        txn_valid;
  logic        txn_ready;
  logic [6:0]  txn_addr;
  logic [15:0] txn_data;
  logic        txn_done;
  logic        txn_nack;
  logic        upd_valid;
  logic        upd_ready;
  logic [6:0]  upd_reg;
  logic [8:0]  upd_data;
  logic        init_done;
  logic        busy;
  logic        error;
  logic [2:0]  cur_index;

  codec_cfg_sequencer #(
    .DEV_ADDR      (DEV_ADDR),
    .STARTUP_CYCLES(STARTUP),
    .GAP_CYCLES    (GAP),
    .MAX_RETRY     (RETRY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .txn_valid(txn_valid),
    .txn_ready(txn_ready),
    .txn_addr (txn_addr),
    .txn_data (txn_data),
    .txn_done (txn_done),
    .txn_nack (txn_nack),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_reg  (upd_reg),
    .upd_data (upd_data),
    .init_done(init_done),
    .busy     (busy),
    .error    (error),
    .cur_index(cur_index)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [6:0] tbl_reg [7] = '{7'h0F, 7'h06, 7'h07, 7'h08, 7'h04, 7'h05, 7'h09};
  logic [8:0] tbl_dat [7] = '{9'h000, 9'h000, 9'h00A, 9'h000, 9'h012, 9'h000, 9'h001};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string pfx);
    check_value({pfx, "_valid"},     txn_valid, 0);
    check_value({pfx, "_data"},      txn_data, 0);
    check_value({pfx, "_addr"},      txn_addr, DEV_ADDR);
    check_value({pfx, "_upd_ready"}, upd_ready, 0);
    check_value({pfx, "_init_done"}, init_done, 0);
    check_value({pfx, "_busy"},      busy, 1);
    check_value({pfx, "_error"},     error, 0);
    check_value({pfx, "_index"},     cur_index, 0);
  endtask

  task automatic apply_reset();
    txn_ready = 1'b0;
    txn_done  = 1'b0;
    txn_nack  = 1'b0;
    reset     = 1'b1;
    step();
    step();
    check_reset_state("rst");
    reset = 1'b0;
  endtask

  // Reset was released just after an edge; the first request must be seen
  // after STARTUP+1 further edges.
  task automatic boot_check(output bit ok);
    int k;
    step();
    k = 1;
    check_value("boot_busy", busy, 1);
    check_value("boot_upd_ready", upd_ready, 0);
    check_value("boot_data", txn_data, 0);
    while (!txn_valid && k < STARTUP + 20) begin
      step();
      k++;
    end
    check_value("boot_latency", k, STARTUP + 1);
    ok = txn_valid;
  endtask

  task automatic run_session(input int nack_pct, input int always_nack_idx,
                             input int nack_once_idx, input int reset_idx,
                             input int stall_idx, input int stall_max,
                             input bit early_upd, input int n_upd);
    int idx, attempts, upd_left, k, stall, lat, bad;
    bit init_exp, err_exp, upd_active, once_used, reset_used, ok, n, expect_issue;
    logic [15:0] exp_word, upd_word;
    idx = 0; attempts = 0; upd_left = n_upd;
    init_exp = 0; err_exp = 0; upd_active = 0; once_used = 0; reset_used = 0;
    upd_word = '0;
    upd_valid = 1'b0;
    if (early_upd && n_upd > 0) begin
      upd_valid = 1'b1;
      upd_reg   = 7'h02;
      upd_data  = 9'h179;
    end
    apply_reset();
    boot_check(ok);
    if (!ok) return;

    for (int t = 0; t < 100; t++) begin
      // --- request phase: txn_valid is high here ---
      exp_word = upd_active ? upd_word : {tbl_reg[idx], tbl_dat[idx]};
      check_value("issue_data", txn_data, exp_word);
      check_value("issue_addr", txn_addr, DEV_ADDR);
      check_value("issue_upd_ready", upd_ready, 0);
      check_value("issue_index", cur_index, upd_active ? 6 : idx);
      stall = (!upd_active && idx == stall_idx) ? 20 : int'($urandom_range(stall_max, 0));
      bad = 0;
      for (int s = 0; s < stall; s++) begin
        step();
        if (!txn_valid || txn_data !== exp_word) bad++;
      end
      check_value("stall_hold", bad, 0);
      txn_ready = 1'b1;
      step();
      txn_ready = 1'b0;
      check_value("accept_drop", txn_valid, 0);
      $display("txn word=0x%04h idx=%0d upd=%0d attempt=%0d", exp_word, idx, upd_active, attempts + 1);

      if (reset_idx == idx && !upd_active && !reset_used) begin
        reset_used = 1;
        step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        step();
        step();
        reset = 1'b0;
        idx = 0; attempts = 0; init_exp = 0;
        boot_check(ok);
        if (!ok) return;
        continue;
      end

      lat = int'($urandom_range(3, 0));
      for (int s = 0; s < lat; s++) step();

      // --- completion ---
      if (!upd_active && idx == always_nack_idx) n = 1;
      else if (!upd_active && idx == nack_once_idx && !once_used) begin
        n = 1;
        once_used = 1;
      end else n = ($urandom_range(99, 0) < nack_pct);
      txn_done = 1'b1;
      txn_nack = n;
      step();
      txn_done = 1'b0;
      txn_nack = 1'b0;

      if (!n) begin
        attempts = 0;
        if (upd_active) upd_active = 0;
        else if (idx == 6) init_exp = 1;
        else idx++;
      end else begin
        attempts++;
        if (attempts >= RETRY) err_exp = 1;
      end
      check_value("done_error", error, err_exp);
      check_value("done_init_done", init_done, init_exp);
      check_value("done_valid", txn_valid, 0);

      if (err_exp) begin
        check_value("err_upd_ready", upd_ready, 0);
        check_value("err_busy", busy, 0);
        bad = 0;
        for (int s = 0; s < GAP + 5; s++) begin
          step();
          if (txn_valid || upd_ready || !error || (init_done !== init_exp)) bad++;
        end
        check_value("err_terminal", bad, 0);
        upd_valid = 1'b0;
        return;
      end

      // --- gap: count to the next request or to idle ---
      expect_issue = !init_exp || attempts > 0;
      k = 0;
      bad = 0;
      do begin
        step();
        k++;
        txn_done = 1'b0;
        txn_nack = 1'b0;
        if (expect_issue && upd_ready) bad++;
        // A stray completion pulse outside the wait state must change nothing.
        if (k == 2 && $urandom_range(1, 0) == 1) begin
          txn_done = 1'b1;
          txn_nack = 1'($urandom);
        end
      end while (!(expect_issue ? txn_valid : upd_ready) && k < GAP + 20);
      txn_done = 1'b0;
      txn_nack = 1'b0;
      check_value(expect_issue ? "gap_to_issue" : "gap_to_idle", k, GAP + 1);
      check_value("gap_upd_ready", bad, 0);
      if (k != GAP + 1) return;

      if (!expect_issue) begin
        check_value("idle_busy", busy, 0);
        check_value("idle_init_done", init_done, 1);
        check_value("idle_index", cur_index, 6);
        if (upd_left == 0) return;
        if (!upd_valid) begin
          upd_valid = 1'b1;
          upd_reg   = 7'($urandom);
          upd_data  = 9'($urandom);
        end
        upd_word = {upd_reg, upd_data};
        step();
        upd_valid = 1'b0;
        check_value("upd_issue", txn_valid, 1);
        upd_active = 1;
        upd_left--;
      end
    end
  endtask

  initial begin
    txn_ready = 1'b0;
    txn_done  = 1'b0;
    txn_nack  = 1'b0;
    upd_valid = 1'b0;
    upd_reg   = '0;
    upd_data  = '0;

    // clean boot, 20-cycle stall at index 2, update 0x02/0x179 held from reset
    run_session(0, -1, -1, -1, 2, 0, 1'b1, 1);
    // single NACK on index 3
    run_session(0, -1, 3, -1, -1, 1, 1'b0, 1);
    // index 1 NACKs every attempt; pending update must never be taken
    run_session(0, 1, -1, -1, -1, 1, 1'b1, 1);
    // reset while waiting for completion of index 4
    run_session(0, -1, -1, 4, -1, 2, 1'b0, 1);
    // random NACKs, stalls and several runtime updates
    for (int r = 0; r < 4; r++) begin
      run_session(25, -1, -1, -1, -1, 4, 1'b0, 3);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", checks_passed, checks_total);
    $fatal(1);
  end

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Transaction-level scheduler that configures the WM8731 codec over the shared I2C byte controller. After reset it waits a power-up delay, walks a fixed 7-entry register table, then arbitrates runtime register updates (volume, mute) onto the same I2C master. It handles NACK retry, inter-transaction spacing and sticky error reporting. It sits between the synth control logic and the I2C master, which owns the SDA/SCL pins.

## Interface
Parameters:
- DEV_ADDR, 7'b0011010, WM8731 7-bit device address (CSB=0)
- STARTUP_CYCLES, 50000, delay after reset before the first transaction (1 ms at 50 MHz); 20-bit counter
- GAP_CYCLES, 500, idle cycles between the end of one transaction and the next issue; also applied before a retry
- MAX_RETRY, 3, maximum number of attempts per transaction (first attempt included)

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- txn_valid  out  1  transaction request to the I2C master
- txn_ready  in  1  the I2C master is idle and able to accept a transaction
- txn_addr  out  7  device address; always DEV_ADDR
- txn_data  out  16  WM8731 word: [15:9] register, [8:0] data
- txn_done  in  1  one-cycle pulse when the transaction completes
- txn_nack  in  1  valid only with txn_done; 1 means the device NACKed
- upd_valid  in  1  runtime update request
- upd_ready  out  1  the sequencer accepts an update this cycle
- upd_reg  in  7  register for the runtime update
- upd_data  in  9  data for the runtime update
- init_done  out  1  set when the init table completes; sticky
- busy  out  1  1 in every state except S_IDLE and S_ERROR
- error  out  1  set when retries are exhausted; sticky until reset
- cur_index  out  3  index of the current init table entry

## Operation
Init table, indices 0–6, as {reg, data}:
- 0: {0x0F, 0x000} — reset
- 1: {0x06, 0x000} — power on
- 2: {0x07, 0x00A} — I2S, 24-bit
- 3: {0x08, 0x000} — 48 kHz normal
- 4: {0x04, 0x012} — DACSEL, mic mute
- 5: {0x05, 0x000} — DAC unmute
- 6: {0x09, 0x001} — active

States and transitions:
- S_BOOT_WAIT: count STARTUP_CYCLES, then go to S_ISSUE with index 0.
- S_ISSUE: txn_valid=1 and txn_data is driven from the table, or from the latched update if the update flag is set. On txn_valid&&txn_ready, go to S_WAIT.
- S_WAIT: wait for txn_done.
  - If txn_nack=0: clear the retry count. For an init entry, advance the index; after index 6, set init_done. Go to S_GAP.
  - If txn_nack=1: increment the retry count. If the attempt count reaches MAX_RETRY, go to S_ERROR; otherwise go to S_GAP and reissue the same word.
- S_GAP: count GAP_CYCLES. Then go to S_ISSUE if init or a retry is still pending; otherwise go to S_IDLE.
- S_IDLE: upd_ready=1. On upd_valid, latch {upd_reg, upd_data}, set the update flag, and go to S_ISSUE. The update flag clears on successful completion.
- S_ERROR: terminal. error=1, txn_valid=0, upd_ready=0.

Rules:
- upd_ready is 1 only in S_IDLE, so runtime updates are held off during init and during any transaction or gap.
- txn_data and txn_addr stay stable while txn_valid=1; txn_valid never drops before acceptance.
- txn_done outside S_WAIT is ignored.

## Timing
- Reset values: txn_valid=0, txn_data=0, txn_addr=DEV_ADDR, upd_ready=0, init_done=0, busy=1, error=0, cur_index=0. State is S_BOOT_WAIT and all counters are 0.
- First txn_valid rises STARTUP_CYCLES+1 cycles after reset deasserts.
- Acceptance is the cycle in which txn_valid&&txn_ready are both 1; txn_valid is 0 on the next cycle.
- From the txn_done cycle to the next txn_valid is exactly GAP_CYCLES+1 cycles.
- upd_ready=1 → upd_valid accepted in that cycle → txn_valid on the next cycle.
- init_done rises one cycle after the successful txn_done for index 6.
- error rises one cycle after the final NACK.
- Reset mid-transaction: return immediately to S_BOOT_WAIT and restart the full table. The I2C master is reset by the same signal.

## Test plan
- Boot, I2C slave model always ACKs and txn_ready=1 → seven transactions with txn_data 0x1E00, 0x0C00, 0x0E0A, 0x1000, 0x0812, 0x0A00, 0x1201 in that order; init_done=1; busy=0.
- txn_ready held low for 20 cycles at index 2 → txn_valid stays high with txn_data stable at 0x0E0A; exactly one acceptance.
- NACK on index 3, first attempt only → 0x1000 is issued twice, GAP_CYCLES apart; error=0; init completes normally.
- NACK on every attempt at index 1 → exactly 3 attempts; then error=1, txn_valid=0, upd_ready=0; init_done stays 0.
- upd_valid with reg 0x02, data 0x179 asserted from reset → held off until init_done; then txn_data=0x0579; upd_ready is low during that transaction and its gap.
- Reset asserted in S_WAIT of index 4 → outputs return to reset values; after release, the sequence restarts at 0x1E00 after STARTUP_CYCLES.
